// File: rtl/hazard_pkg.sv
// Shared encodings, shadow-stage records and selection helpers for the hazard controller.
package hazard_pkg;

    // Result source encodings.
    localparam logic [1:0] SrcAlu = 2'b00;
    localparam logic [1:0] SrcDm  = 2'b01;
    localparam logic [1:0] SrcPc8 = 2'b10;

    // A Tuse of 3 marks an operand the instruction never reads.
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Result latency counted from E entry.
    localparam logic [1:0] TnewAlu = 2'd1;
    localparam logic [1:0] TnewDm  = 2'd2;
    localparam logic [1:0] TnewPc8 = 2'd0;

    // D-stage compare mux selects.
    localparam logic [2:0] FwdDGrf  = 3'b000;
    localparam logic [2:0] FwdDPc8E = 3'b001;
    localparam logic [2:0] FwdDAluM = 3'b010;
    localparam logic [2:0] FwdDPc8M = 3'b011;
    localparam logic [2:0] FwdDWb   = 3'b100;
    localparam logic [2:0] FwdDPc8W = 3'b101;

    // E-stage ALU operand mux selects.
    localparam logic [2:0] FwdERs   = 3'b000;
    localparam logic [2:0] FwdEAluM = 3'b001;
    localparam logic [2:0] FwdEPc8M = 3'b010;
    localparam logic [2:0] FwdEWb   = 3'b011;
    localparam logic [2:0] FwdEPc8W = 3'b100;

    // M-stage store data mux selects.
    localparam logic [1:0] FwdMRt   = 2'b00;
    localparam logic [1:0] FwdMWb   = 2'b01;
    localparam logic [1:0] FwdMPc8W = 2'b10;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] a3;
        logic [1:0] tnew;
        logic [1:0] src;
        logic       md_start;
        logic       md_div;
    } e_stage_t;

    typedef struct packed {
        logic [4:0] rt;
        logic [4:0] a3;
        logic [1:0] tnew;
        logic [1:0] src;
    } m_stage_t;

    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] src;
    } w_stage_t;

    // $0 is hardwired, so a zero destination never produces a match.
    function automatic logic reg_match(input logic [4:0] a3, input logic [4:0] r);
        return (a3 != 5'd0) && (a3 == r);
    endfunction

    function automatic logic [1:0] tnew_dec(input logic [1:0] tnew);
        return (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
    endfunction

    // Newest matching stage wins; a match that is not ready yet masks older stages.
    function automatic logic [2:0] fwd_d_sel(input logic [4:0] r, input e_stage_t e,
                                             input m_stage_t m, input w_stage_t w);
        if (reg_match(e.a3, r)) begin
            return (e.tnew == 2'd0) ? FwdDPc8E : FwdDGrf;
        end else if (reg_match(m.a3, r)) begin
            if (m.tnew != 2'd0) return FwdDGrf;
            return (m.src == SrcPc8) ? FwdDPc8M : FwdDAluM;
        end else if (reg_match(w.a3, r)) begin
            return (w.src == SrcPc8) ? FwdDPc8W : FwdDWb;
        end
        return FwdDGrf;
    endfunction

    function automatic logic [2:0] fwd_e_sel(input logic [4:0] r, input m_stage_t m,
                                             input w_stage_t w);
        if (reg_match(m.a3, r) && (m.tnew == 2'd0)) begin
            return (m.src == SrcPc8) ? FwdEPc8M : FwdEAluM;
        end else if (reg_match(w.a3, r)) begin
            return (w.src == SrcPc8) ? FwdEPc8W : FwdEWb;
        end
        return FwdERs;
    endfunction

    function automatic logic [1:0] fwd_m_sel(input logic [4:0] r, input w_stage_t w);
        if (reg_match(w.a3, r)) begin
            return (w.src == SrcPc8) ? FwdMPc8W : FwdMWb;
        end
        return FwdMRt;
    endfunction

    function automatic logic raw_hazard(input logic [4:0] r, input logic [1:0] tuse,
                                        input e_stage_t e, input m_stage_t m);
        if (tuse == TUSE_NONE) return 1'b0;
        return (reg_match(e.a3, r) && (tuse < e.tnew)) ||
               (reg_match(m.a3, r) && (tuse < m.tnew));
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Busy window of the multiply/divide unit: loads a cycle count when a start leaves E.
module md_busy_counter
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic start_i,
    input  logic div_i,
    output logic busy_o
);

    localparam int unsigned MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Load on start, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = div_i ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The start cycle itself already counts as occupied.
    assign busy_o = (cnt_q != '0) | start_i;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Stall and forwarding controller for the 5-stage core, tracking E/M/W destinations.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [4:0] d_rs_i,
    input  logic [4:0] d_rt_i,
    input  logic [4:0] d_a3_i,
    input  logic [1:0] d_tuse_rs_i,
    input  logic [1:0] d_tuse_rt_i,
    input  logic [1:0] d_tnew_i,
    input  logic [1:0] d_src_i,
    input  logic       d_md_start_i,
    input  logic       d_md_div_i,
    input  logic       d_md_use_i,
    output logic       stall_o,
    output logic [2:0] fwd_rs_d_o,
    output logic [2:0] fwd_rt_d_o,
    output logic [2:0] fwd_rs_e_o,
    output logic [2:0] fwd_rt_e_o,
    output logic [1:0] fwd_rt_m_o,
    output logic       md_start_o,
    output logic       md_busy_o
);

    e_stage_t e_q, e_d;
    m_stage_t m_q, m_d;
    w_stage_t w_q, w_d;

    logic stall_raw;
    logic stall_md;
    logic md_busy;

    // Shadow pipeline advance; a stall injects a bubble into E while M and W keep moving.
    always_comb begin
        e_d = '0;
        if (!stall_o) begin
            e_d.rs       = d_rs_i;
            e_d.rt       = d_rt_i;
            e_d.a3       = d_a3_i;
            e_d.tnew     = d_tnew_i;
            e_d.src      = d_src_i;
            e_d.md_start = d_md_start_i;
            e_d.md_div   = d_md_div_i;
        end
        m_d.rt   = e_q.rt;
        m_d.a3   = e_q.a3;
        m_d.tnew = tnew_dec(e_q.tnew);
        m_d.src  = e_q.src;
        w_d.a3   = m_q.a3;
        w_d.src  = m_q.src;
    end

    // Shadow stage registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    md_busy_counter #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_busy_counter (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .start_i(e_q.md_start),
        .div_i  (e_q.md_div),
        .busy_o (md_busy)
    );

    // Stall and forward selects, all combinational from the shadows and D fields.
    always_comb begin
        stall_raw  = raw_hazard(d_rs_i, d_tuse_rs_i, e_q, m_q) |
                     raw_hazard(d_rt_i, d_tuse_rt_i, e_q, m_q);
        stall_md   = d_md_use_i & md_busy;
        stall_o    = ~reset_i & (stall_raw | stall_md);
        fwd_rs_d_o = fwd_d_sel(d_rs_i, e_q, m_q, w_q);
        fwd_rt_d_o = fwd_d_sel(d_rt_i, e_q, m_q, w_q);
        fwd_rs_e_o = fwd_e_sel(e_q.rs, m_q, w_q);
        fwd_rt_e_o = fwd_e_sel(e_q.rt, m_q, w_q);
        fwd_rt_m_o = fwd_m_sel(m_q.rt, w_q);
    end

    assign md_start_o = e_q.md_start;
    assign md_busy_o  = md_busy;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl with hand-computed expectations.
module tb_hazard_fwd_ctrl;

    localparam int unsigned MultCycles = 5;
    localparam int unsigned DivCycles  = 10;

    logic       clk;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_a3;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew, d_src;
    logic       d_md_start, d_md_div, d_md_use;
    logic       stall;
    logic [2:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic [1:0] fwd_rt_m;
    logic       md_start, md_busy;

    int n_checks = 0;
    int n_errors = 0;

    hazard_fwd_ctrl #(
        .MULT_CYCLES(MultCycles),
        .DIV_CYCLES (DivCycles)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .d_rs_i      (d_rs),
        .d_rt_i      (d_rt),
        .d_a3_i      (d_a3),
        .d_tuse_rs_i (d_tuse_rs),
        .d_tuse_rt_i (d_tuse_rt),
        .d_tnew_i    (d_tnew),
        .d_src_i     (d_src),
        .d_md_start_i(d_md_start),
        .d_md_div_i  (d_md_div),
        .d_md_use_i  (d_md_use),
        .stall_o     (stall),
        .fwd_rs_d_o  (fwd_rs_d),
        .fwd_rt_d_o  (fwd_rt_d),
        .fwd_rs_e_o  (fwd_rs_e),
        .fwd_rt_e_o  (fwd_rt_e),
        .fwd_rt_m_o  (fwd_rt_m),
        .md_start_o  (md_start),
        .md_busy_o   (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the D-stage fields; settle before any check.
    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] a3,
                         input logic [1:0] tuse_rs, input logic [1:0] tuse_rt,
                         input logic [1:0] tnew, input logic [1:0] src,
                         input logic md_st, input logic md_dv, input logic md_us);
        d_rs       = rs;
        d_rt       = rt;
        d_a3       = a3;
        d_tuse_rs  = tuse_rs;
        d_tuse_rt  = tuse_rt;
        d_tnew     = tnew;
        d_src      = src;
        d_md_start = md_st;
        d_md_div   = md_dv;
        d_md_use   = md_us;
        #1;
    endtask

    task automatic set_nop();
        set_d(5'd0, 5'd0, 5'd0, 2'd3, 2'd3, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        set_nop();
        tick();
        tick();
        // Stall is forced low while reset is high, even with an MD user in D.
        set_d(5'd0, 5'd0, 5'd5, 2'd3, 2'd3, 2'd1, 2'b00, 1'b0, 1'b0, 1'b1);
        check("stall_in_reset", 8'(stall), 8'd0);
        set_nop();
        reset = 1'b0;
        #1;
        check("rst_stall", 8'(stall), 8'd0);
        check("rst_fwd_rs_d", 8'(fwd_rs_d), 8'd0);
        check("rst_fwd_rt_d", 8'(fwd_rt_d), 8'd0);
        check("rst_fwd_rs_e", 8'(fwd_rs_e), 8'd0);
        check("rst_fwd_rt_e", 8'(fwd_rt_e), 8'd0);
        check("rst_fwd_rt_m", 8'(fwd_rt_m), 8'd0);
        check("rst_md_start", 8'(md_start), 8'd0);
        check("rst_md_busy", 8'(md_busy), 8'd0);

        // addu $1 then beq $1: one stall, then forward ALUResult_M.
        set_d(5'd5, 5'd6, 5'd1, 2'd1, 2'd1, 2'd1, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd1, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        check("beq_stall", 8'(stall), 8'd1);
        check("beq_mask_e", 8'(fwd_rs_d), 8'b000);
        tick();
        check("beq_release", 8'(stall), 8'd0);
        check("beq_fwd_alu_m", 8'(fwd_rs_d), 8'b010);
        tick();

        // lw $2 then addu $3,$2: one stall, then W forward in E.
        set_d(5'd7, 5'd2, 5'd2, 2'd1, 2'd3, 2'd2, 2'b01, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd2, 5'd8, 5'd3, 2'd1, 2'd1, 2'd1, 2'b00, 1'b0, 1'b0, 1'b0);
        check("lw_use_stall", 8'(stall), 8'd1);
        tick();
        check("lw_use_release", 8'(stall), 8'd0);
        check("lw_mask_m_d", 8'(fwd_rs_d), 8'b000);
        tick();
        set_nop();
        check("lw_fwd_rs_e_wb", 8'(fwd_rs_e), 8'b011);
        check("lw_fwd_rt_e_none", 8'(fwd_rt_e), 8'b000);
        tick();
        tick();
        tick();

        // jal then jr $31: no stall, PC8_E forward; then PC8_M in E.
        set_d(5'd0, 5'd0, 5'd31, 2'd3, 2'd3, 2'd0, 2'b10, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd31, 5'd0, 5'd0, 2'd0, 2'd3, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        check("jr_stall", 8'(stall), 8'd0);
        check("jr_fwd_pc8_e", 8'(fwd_rs_d), 8'b001);
        tick();
        set_nop();
        check("jr_fwd_e_pc8_m", 8'(fwd_rs_e), 8'b010);
        tick();
        tick();
        tick();

        // addu $4 then sw $4: E forward ALU_M, then store forward from W.
        set_d(5'd5, 5'd6, 5'd4, 2'd1, 2'd1, 2'd1, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd9, 5'd4, 5'd0, 2'd1, 2'd2, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        check("sw_no_stall", 8'(stall), 8'd0);
        tick();
        set_nop();
        check("sw_fwd_rt_e_alu", 8'(fwd_rt_e), 8'b001);
        tick();
        check("sw_fwd_rt_m_wb", 8'(fwd_rt_m), 8'b01);
        tick();
        tick();

        // jal writing $4 then sw $4: PC8 forwards in E and M.
        set_d(5'd0, 5'd0, 5'd4, 2'd3, 2'd3, 2'd0, 2'b10, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd9, 5'd4, 5'd0, 2'd1, 2'd2, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        set_nop();
        check("sw_fwd_rt_e_pc8", 8'(fwd_rt_e), 8'b010);
        tick();
        check("sw_fwd_rt_m_pc8", 8'(fwd_rt_m), 8'b10);
        tick();
        tick();

        // div leaves E, mflo arrives next cycle: stall for DivCycles cycles.
        set_d(5'd10, 5'd11, 5'd0, 2'd1, 2'd1, 2'd0, 2'b00, 1'b1, 1'b1, 1'b1);
        check("div_d_no_stall", 8'(stall), 8'd0);
        tick();
        set_nop();
        check("div_md_start", 8'(md_start), 8'd1);
        check("div_md_busy", 8'(md_busy), 8'd1);
        tick();
        set_d(5'd0, 5'd0, 5'd5, 2'd3, 2'd3, 2'd1, 2'b00, 1'b0, 1'b0, 1'b1);
        check("div_md_start_gone", 8'(md_start), 8'd0);
        for (int i = 0; i < int'(DivCycles); i++) begin
            check($sformatf("div_stall_%0d", i), 8'(stall), 8'd1);
            tick();
        end
        check("div_release", 8'(stall), 8'd0);
        check("div_idle", 8'(md_busy), 8'd0);
        tick();

        // mult in E with mfhi in D: stall covers the start cycle plus MultCycles.
        set_d(5'd10, 5'd11, 5'd0, 2'd1, 2'd1, 2'd0, 2'b00, 1'b1, 1'b0, 1'b1);
        tick();
        set_d(5'd0, 5'd0, 5'd6, 2'd3, 2'd3, 2'd1, 2'b00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < int'(MultCycles) + 1; i++) begin
            check($sformatf("mult_stall_%0d", i), 8'(stall), 8'd1);
            tick();
        end
        check("mult_release", 8'(stall), 8'd0);
        tick();

        // Writers of $0 in E and M never match a reader of $0.
        set_d(5'd0, 5'd0, 5'd0, 2'd1, 2'd3, 2'd2, 2'b01, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 5'd0, 2'd1, 2'd1, 2'd1, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        check("r0_stall", 8'(stall), 8'd0);
        check("r0_fwd_rs_d", 8'(fwd_rs_d), 8'd0);
        check("r0_fwd_rt_d", 8'(fwd_rt_d), 8'd0);
        check("r0_fwd_rs_e", 8'(fwd_rs_e), 8'd0);
        check("r0_fwd_rt_e", 8'(fwd_rt_e), 8'd0);
        check("r0_fwd_rt_m", 8'(fwd_rt_m), 8'd0);
        tick();
        set_nop();
        tick();
        tick();

        // Reset in the middle of a divide clears the busy window.
        set_d(5'd10, 5'd11, 5'd0, 2'd1, 2'd1, 2'd0, 2'b00, 1'b1, 1'b1, 1'b1);
        tick();
        set_nop();
        tick();
        tick();
        check("rdiv_busy", 8'(md_busy), 8'd1);
        set_d(5'd0, 5'd0, 5'd5, 2'd3, 2'd3, 2'd1, 2'b00, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        check("rdiv_stall_forced", 8'(stall), 8'd0);
        tick();
        check("rdiv_busy_cleared", 8'(md_busy), 8'd0);
        check("rdiv_stall_in_reset", 8'(stall), 8'd0);
        reset = 1'b0;
        #1;
        check("rdiv_stall_after", 8'(stall), 8'd0);
        check("rdiv_busy_after", 8'(md_busy), 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
